msd_serial_mac: RTL and testbench

Multi-lane, term-serial successor to the combinational bit-serial multiplier in the MSD datapath. It latches a vector of `LANES` unsigned activations and accepts one signed-power-of-two weight term per cycle. Each term is a sign bit plus a shift index, and the block accumulates ±(act << shift) per lane into a `PSU_DW` partial sum. When the last term arrives, the partial-sum vector is presented under a valid/ready handshake. It sits between the activation buffer and the PSU adder tree.

---
 rtl/msd_serial_mac.sv | 154 +++++++++++++++
 tb/tb_msd_serial_mac.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msd_serial_mac.sv
// Multi-lane term-serial MAC: latches LANES activations, then accumulates +/-(act << shift) per lane.
// Define MSD_MAC_SAT_EN for saturating accumulation; the default build wraps modulo 2^PSU_DW.
`ifndef HW_IDX_DW
`define HW_IDX_DW 3
`endif
`ifndef HW_ACT_DW
`define HW_ACT_DW 8
`endif
`ifndef HW_PSU_DW
`define HW_PSU_DW 24
`endif

module msd_serial_mac #(
   parameter int IDX_DW    = `HW_IDX_DW,
   parameter int ACT_DW    = `HW_ACT_DW,
   parameter int PSU_DW    = `HW_PSU_DW,
   parameter int LANES     = 4,
   parameter int MAX_TERMS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     act_valid,
   output logic                     act_ready,
   input  logic [LANES*ACT_DW-1:0]  act_in,
   input  logic                     term_valid,
   output logic                     term_ready,
   input  logic [IDX_DW-1:0]        term_in,
   input  logic                     term_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*PSU_DW-1:0]  psu_out,
   output logic                     err_ovf
);

   localparam int SH_DW  = IDX_DW - 1;
   localparam int CNT_DW = $clog2(MAX_TERMS + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [LANES-1:0][ACT_DW-1:0]    act_q, act_d;
   logic [LANES-1:0][PSU_DW-1:0]    acc_q, acc_d;
   logic [CNT_DW-1:0]               cnt_q, cnt_d;
   logic                            err_q, err_d;

   logic [LANES-1:0][PSU_DW-1:0]    mag;
   logic [LANES-1:0][PSU_DW-1:0]    addend;
   logic [LANES-1:0][PSU_DW-1:0]    sum;
   logic [CNT_DW-1:0]               cnt_inc;
   logic                            term_neg;
   logic [SH_DW-1:0]                term_sh;
   logic                            term_nop;

   assign term_neg = term_in[IDX_DW-1];
   assign term_sh  = term_in[SH_DW-1:0];
   // An all-ones shift field encodes a zero weight: it counts as a term but adds nothing.
   assign term_nop = &term_sh;
   assign cnt_inc  = cnt_q + CNT_DW'(1);

`ifdef MSD_MAC_SAT_EN
   localparam logic [PSU_DW-1:0] POS_MAX = {1'b0, {(PSU_DW-1){1'b1}}};
   localparam logic [PSU_DW-1:0] NEG_MIN = {1'b1, {(PSU_DW-1){1'b0}}};
   logic [LANES-1:0][PSU_DW:0]      wide;
`endif

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         mag[i] = {{(PSU_DW-ACT_DW){1'b0}}, act_q[i]} << term_sh;
         if (term_nop) begin
            addend[i] = '0;
         end else if (term_neg) begin
            addend[i] = ~mag[i] + PSU_DW'(1);
         end else begin
            addend[i] = mag[i];
         end
`ifdef MSD_MAC_SAT_EN
         // One extra bit exposes signed overflow; clamp toward the sign of the true result.
         wide[i] = {acc_q[i][PSU_DW-1], acc_q[i]} + {addend[i][PSU_DW-1], addend[i]};
         if (wide[i][PSU_DW] != wide[i][PSU_DW-1]) begin
            sum[i] = wide[i][PSU_DW] ? NEG_MIN : POS_MAX;
         end else begin
            sum[i] = wide[i][PSU_DW-1:0];
         end
`else
         sum[i] = acc_q[i] + addend[i];
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (act_valid) begin
               act_d   = act_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (term_valid) begin
               acc_d = sum;
               cnt_d = cnt_inc;
               if (term_last) begin
                  state_d = DONE;
               end else if (cnt_inc == CNT_DW'(MAX_TERMS)) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         act_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign act_ready  = (state_q == IDLE);
   assign term_ready = (state_q == RUN);
   assign out_valid  = (state_q == DONE);
   assign psu_out    = acc_q;
   assign err_ovf    = err_q;

endmodule

// File: tb/tb_msd_serial_mac.sv
// Bench for msd_serial_mac: an integer-arithmetic job model checked every cycle, plus directed literal checks.
// Honours MSD_MAC_SAT_EN for the expected saturation results.
module tb_msd_serial_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        act_valid, act_ready, term_valid, term_ready, term_last;
   logic        out_valid, out_ready, err_ovf;
   logic [31:0] act_in;
   logic [2:0]  term_in;
   logic [95:0] psu_out;

   logic        s_act_valid, s_act_ready, s_term_valid, s_term_ready, s_term_last;
   logic        s_out_valid, s_out_ready, s_err_ovf;
   logic [31:0] s_act_in;
   logic [2:0]  s_term_in;
   logic [47:0] s_psu_out;

   int checks = 0;
   int errors = 0;

   int     m_phase;
   longint m_acc [4];
   longint m_act [4];
   int     m_cnt;
   bit     m_err;
   bit     m_live = 1'b0;

`ifdef MSD_MAC_SAT_EN
   localparam longint SAT_L0 = 2047;
   localparam longint SAT_L3 = 2047;
`else
   localparam longint SAT_L0 = 12'hFE0;
   localparam longint SAT_L3 = 12'hC80;
`endif

   always #5 clk = ~clk;

   msd_serial_mac #(.IDX_DW(3), .ACT_DW(8), .PSU_DW(24), .LANES(4), .MAX_TERMS(4)) dut (
      .clk(clk), .rst(rst),
      .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
      .term_valid(term_valid), .term_ready(term_ready), .term_in(term_in), .term_last(term_last),
      .out_valid(out_valid), .out_ready(out_ready), .psu_out(psu_out), .err_ovf(err_ovf)
   );

   msd_serial_mac #(.IDX_DW(3), .ACT_DW(8), .PSU_DW(12), .LANES(4), .MAX_TERMS(8)) dut_sat (
      .clk(clk), .rst(rst),
      .act_valid(s_act_valid), .act_ready(s_act_ready), .act_in(s_act_in),
      .term_valid(s_term_valid), .term_ready(s_term_ready), .term_in(s_term_in), .term_last(s_term_last),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .psu_out(s_psu_out), .err_ovf(s_err_ovf)
   );

   // Reduce an exact integer sum to what a 24-bit signed lane can hold.
   function automatic longint fold24(input longint v);
      longint r;
`ifdef MSD_MAC_SAT_EN
      if (v > 64'sd8388607) r = 64'sd8388607;
      else if (v < -64'sd8388608) r = -64'sd8388608;
      else r = v;
`else
      r = v & 64'hFFFFFF;
      if (r >= 64'sd8388608) r = r - 64'sd16777216;
`endif
      return r;
   endfunction

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Advance the job model by one clock using the inputs the bench is driving.
   task automatic model_update();
      longint v;
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
         m_err   = 1'b0;
         for (int i = 0; i < 4; i++) m_acc[i] = 0;
         m_live  = 1'b1;
      end else begin
         m_err = 1'b0;
         if (m_phase == 0) begin
            if (act_valid) begin
               for (int i = 0; i < 4; i++) begin
                  m_act[i] = longint'(act_in[i*8 +: 8]);
                  m_acc[i] = 0;
               end
               m_cnt   = 0;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (term_valid) begin
               for (int i = 0; i < 4; i++) begin
                  if (term_in[1:0] != 2'b11) begin
                     v = m_act[i] * (64'sd1 << term_in[1:0]);
                     if (term_in[2]) v = -v;
                     m_acc[i] = fold24(m_acc[i] + v);
                  end
               end
               m_cnt = m_cnt + 1;
               if (term_last) begin
                  m_phase = 2;
               end else if (m_cnt == 4) begin
                  m_phase = 2;
                  m_err   = 1'b1;
               end
            end
         end else begin
            if (out_ready) m_phase = 0;
         end
      end
   endtask

   task automatic compare_all();
      if (!m_live) return;
      check_output("act_ready",  longint'(act_ready),  longint'(m_phase == 0));
      check_output("term_ready", longint'(term_ready), longint'(m_phase == 1));
      check_output("out_valid",  longint'(out_valid),  longint'(m_phase == 2));
      check_output("err_ovf",    longint'(err_ovf),    longint'(m_err));
      if (m_phase == 2) begin
         for (int i = 0; i < 4; i++) begin
            check_output($sformatf("psu_lane%0d", i), longint'($signed(psu_out[i*24 +: 24])), m_acc[i]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   function automatic longint lane(input int i);
      return longint'(psu_out[i*24 +: 24]);
   endfunction

   function automatic longint s_lane(input int i);
      return longint'(s_psu_out[i*12 +: 12]);
   endfunction

   task automatic do_act(input logic [31:0] a);
      bit taken = 1'b0;
      act_valid = 1'b1;
      act_in    = a;
      for (int k = 0; k < 8 && !taken; k++) begin
         tick();
         if (m_phase == 1) taken = 1'b1;
      end
      act_valid = 1'b0;
      if (!taken) check_output("act_accept_timeout", 0, 1);
   endtask

   task automatic apply_stimulus(input logic [2:0] t, input bit last, input int stall);
      term_valid = 1'b0;
      repeat (stall) tick();
      term_valid = 1'b1;
      term_in    = t;
      term_last  = last;
      tick();
      term_valid = 1'b0;
      term_last  = 1'b0;
   endtask

   // Hold the result under backpressure while offering traffic that must be ignored, then consume it.
   task automatic do_out(input int hold);
      out_ready = 1'b0;
      repeat (hold) begin
         act_valid  = 1'($urandom);
         act_in     = $urandom;
         term_valid = 1'($urandom);
         term_in    = 3'($urandom);
         tick();
      end
      act_valid  = 1'b0;
      term_valid = 1'b0;
      out_ready  = 1'b1;
      tick();
      out_ready  = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      act_valid = 1'b0; act_in = '0; term_valid = 1'b0; term_in = '0; term_last = 1'b0; out_ready = 1'b0;
      s_act_valid = 1'b0; s_act_in = '0; s_term_valid = 1'b0; s_term_in = '0; s_term_last = 1'b0;
      s_out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_output("reset_act_ready",  longint'(act_ready),  1);
      check_output("reset_term_ready", longint'(term_ready), 0);
      check_output("reset_out_valid",  longint'(out_valid),  0);
      check_output("reset_err_ovf",    longint'(err_ovf),    0);

      // Saturation job on the 12-bit instance: act {255,1,0,100}, eight +<<2 terms.
      s_act_valid = 1'b1;
      s_act_in    = {8'd100, 8'd0, 8'd1, 8'd255};
      tick();
      s_act_valid = 1'b0;
      check_output("sat_term_ready", longint'(s_term_ready), 1);
      for (int k = 0; k < 8; k++) begin
         s_term_valid = 1'b1;
         s_term_in    = 3'b010;
         s_term_last  = (k == 7);
         tick();
         if (k == 6) check_output("sat_not_done_at_7", longint'(s_out_valid), 0);
      end
      s_term_valid = 1'b0;
      s_term_last  = 1'b0;
      check_output("sat_out_valid", longint'(s_out_valid), 1);
      check_output("sat_err_ovf",   longint'(s_err_ovf),   0);
      check_output("sat_lane0",     s_lane(0), SAT_L0);
      check_output("sat_lane1",     s_lane(1), 32);
      check_output("sat_lane2",     s_lane(2), 0);
      check_output("sat_lane3",     s_lane(3), SAT_L3);
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      check_output("sat_idle_after_out", longint'(s_out_valid), 0);

      // Positive and negative terms, then backpressure in DONE.
      do_act({8'd1, 8'd255, 8'd0, 8'd3});
      apply_stimulus(3'b010, 1'b0, 0);
      apply_stimulus(3'b100, 1'b1, 0);
      check_output("pn_out_valid", longint'(out_valid), 1);
      check_output("pn_err_ovf",   longint'(err_ovf),   0);
      check_output("pn_lane0", lane(0), 9);
      check_output("pn_lane1", lane(1), 0);
      check_output("pn_lane2", lane(2), 765);
      check_output("pn_lane3", lane(3), 3);
      do_out(5);
      check_output("bp_act_ready_after_out", longint'(act_ready), 1);

      // Pure negative term, then a NOP-only job.
      do_act({8'd0, 8'd0, 8'd0, 8'd5});
      check_output("bp_next_act_taken", longint'(term_ready), 1);
      apply_stimulus(3'b110, 1'b1, 1);
      check_output("neg_lane0", lane(0), 24'hFFFFEC);
      do_out(0);
      do_act({8'd200, 8'd200, 8'd200, 8'd200});
      apply_stimulus(3'b011, 1'b1, 0);
      for (int i = 0; i < 4; i++) check_output($sformatf("nop_lane%0d", i), lane(i), 0);
      do_out(1);

      // Forced termination at MAX_TERMS.
      do_act({8'd7, 8'd7, 8'd7, 8'd7});
      for (int k = 0; k < 4; k++) apply_stimulus(3'b000, 1'b0, 0);
      check_output("ovf_out_valid", longint'(out_valid), 1);
      check_output("ovf_err_pulse", longint'(err_ovf),   1);
      check_output("ovf_lane0",     lane(0), 28);
      term_valid = 1'b1;
      term_in    = 3'b000;
      tick();
      check_output("ovf_err_cleared", longint'(err_ovf),    0);
      check_output("ovf_fifth_held",  longint'(term_ready), 0);
      check_output("ovf_lane0_hold",  lane(0), 28);
      do_out(0);

      // Reset in the middle of a job.
      do_act({8'd9, 8'd9, 8'd9, 8'd9});
      apply_stimulus(3'b001, 1'b0, 0);
      apply_stimulus(3'b010, 1'b0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("rst_out_valid", longint'(out_valid), 0);
      check_output("rst_act_ready", longint'(act_ready), 1);
      do_act({8'd0, 8'd0, 8'd0, 8'd1});
      apply_stimulus(3'b001, 1'b1, 0);
      check_output("rst_next_lane0", lane(0), 2);
      check_output("rst_next_lane1", lane(1), 0);
      do_out(0);

      // Random jobs: random activations, terms, stalls, job lengths and backpressure.
      for (int j = 0; j < 40; j++) begin
         do_act($urandom);
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) begin
            if (m_phase != 1) break;
            apply_stimulus(3'($urandom), (k == n - 1), int'($urandom_range(0, 2)));
         end
         if (m_phase == 2) do_out(int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
